// File: rtl/alu_pkg.sv
// Shared op-code and FSM state encodings for the ALU / multiply-divide unit.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_ADD   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_SUB   = 5'd4,
        OP_AND   = 5'd5,
        OP_OR    = 5'd6,
        OP_NOR   = 5'd7,
        OP_XOR   = 5'd8,
        OP_SLT   = 5'd9,
        OP_SLTU  = 5'd10,
        OP_EQL   = 5'd11,
        OP_LUI   = 5'd12,
        OP_SLL   = 5'd13,
        OP_SRL   = 5'd14,
        OP_SRA   = 5'd15,
        OP_MULT  = 5'd16,
        OP_MULTU = 5'd17,
        OP_DIV   = 5'd18,
        OP_DIVU  = 5'd19
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic is_mul_op(input logic [4:0] code);
        return (code == OP_MULT) || (code == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] code);
        return (code == OP_DIV) || (code == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply / divide datapath: one product or quotient bit per cycle.
// Signed ops run on operand magnitudes; signs are reapplied to the final value.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             div_i,
    input  logic             sgn_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   hi_q, lo_q, opd_q, a_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q, neg_q, negr_q, dz_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     msum, shifted;
    logic               ge;
    logic [WIDTH-1:0]   dsub, step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;

    assign last_o = run_i && (cnt_q == CW'(WIDTH - 1));

    // Operand magnitudes, one iteration step, and sign/special-case fix-up of the result
    always_comb begin
        a_neg   = sgn_i & a_i[WIDTH-1];
        b_neg   = sgn_i & b_i[WIDTH-1];
        a_mag   = a_neg ? ('0 - a_i) : a_i;
        b_mag   = b_neg ? ('0 - b_i) : b_i;

        msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, opd_q};
        dsub    = shifted[WIDTH-1:0] - opd_q;

        if (div_q) begin
            step_hi = ge ? dsub : shifted[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ge};
        end else begin
            step_hi = msum[WIDTH:1];
            step_lo = {msum[0], lo_q[WIDTH-1:1]};
        end

        prod = {step_hi, step_lo};
        if (neg_q) begin
            prod = '0 - prod;
        end

        if (!div_q) begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end else if (dz_q) begin
            hi_o = a_q;
            lo_o = '1;
        end else begin
            hi_o = negr_q ? ('0 - step_hi) : step_hi;
            lo_o = neg_q  ? ('0 - step_lo) : step_lo;
        end
    end

    // Capture operands at launch, then advance one bit per cycle while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            a_q    <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (load_i) begin
            hi_q   <= '0;
            lo_q   <= a_mag;
            opd_q  <= b_mag;
            a_q    <= a_i;
            cnt_q  <= '0;
            div_q  <= div_i;
            neg_q  <= a_neg ^ b_neg;
            negr_q <= a_neg;
            dz_q   <= (b_i == '0);
        end else if (run_i) begin
            hi_q   <= step_hi;
            lo_q   <= step_lo;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith/shift ops and iterative multiply/divide.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, ovf_q;

    logic             launch, mul_op, div_op, iter_last;
    logic [WIDTH-1:0] sum, diff, alu_res, iter_hi, iter_lo;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;

    assign mul_op = is_mul_op(op);
    assign div_op = is_div_op(op);
    assign launch = (state_q == ST_IDLE) && start;
    assign sum    = a + b;
    assign diff   = a - b;
    assign shamt  = b[SHW-1:0];

    assign result = result_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done   = (state_q == ST_FIN);

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (launch && (mul_op || div_op)),
        .div_i  (div_op),
        .sgn_i  ((op == OP_MULT) || (op == OP_DIV)),
        .run_i  (busy),
        .a_i    (a),
        .b_i    (b),
        .last_o (iter_last),
        .hi_o   (iter_hi),
        .lo_o   (iter_lo)
    );

    // Single-cycle op result; NOP and unknown codes hold the previous result
    always_comb begin
        alu_res = result_q;
        alu_ovf = 1'b0;
        case (op)
            OP_ADDU: alu_res = sum;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_SLT: begin
                alu_res    = '0;
                alu_res[0] = $signed(a) < $signed(b);
            end
            OP_SLTU: begin
                alu_res    = '0;
                alu_res[0] = a < b;
            end
            OP_EQL: begin
                alu_res    = '0;
                alu_res[0] = a == b;
            end
            OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            default: ;
        endcase
    end

    // Next-state: IDLE dispatches by op class, iterative states run to the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mul_op) begin
                        state_d = ST_MUL;
                    end else if (div_op) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (iter_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result registers: single-cycle ops write result/flags, iterative ops write hi/lo
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (launch && !(mul_op || div_op)) begin
                result_q <= alu_res;
                zero_q   <= (a == b);
                ovf_q    <= alu_ovf;
            end
            if (iter_last) begin
                hi_q <= iter_hi;
                lo_q <= iter_lo;
            end
        end
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start  in  1  launch operation (sampled only when busy=0).
REQ-006 SHALL have port op  in  5  operation code (shared package encoding).
REQ-007 SHALL have port a  in  WIDTH  operand 1.
REQ-008 SHALL have port b  in  WIDTH  operand 2; b[SHW-1:0] is the shift amount for shifts.
REQ-009 SHALL have port result  out  WIDTH  registered result of the last completed op.
REQ-010 SHALL have port zero  out  1  registered flag, 1 when a == b at launch.
REQ-011 SHALL have port ovf  out  1  registered signed-overflow flag (ADD/SUB only, else 0).
REQ-012 SHALL have port hi, lo  out  WIDTH each  multiply/divide result registers.
REQ-013 SHALL have port busy  out  1  high while an operation is in flight.
REQ-014 SHALL have port done  out  1  one-cycle pulse when result/hi/lo update.

Function
REQ-015 Ops SHALL be: NOP, ADDU, ADD, SUBU, SUB, AND, OR, NOR (~(a|b)), XOR, SLT (signed), SLTU (unsigned), EQL, LUI ({b[WIDTH/2-1:0], zeros}), SLL, SRL, SRA (arithmetic), MULT, MULTU, DIV, DIVU.
REQ-016 FSM states SHALL be IDLE, MUL, DIV, FIN; IDLE->FIN on start with single-cycle op; IDLE->MUL on MULT/MULTU; IDLE->DIV on DIV/DIVU; MUL/DIV->FIN after WIDTH iterations; FIN->IDLE unconditionally.
REQ-017 Single-cycle ops: start in cycle N -> result/zero/ovf valid and done=1 in cycle N+1; busy=1 only in cycle N+1's FIN... busy SHALL be 0 in FIN, so back-to-back starts every other cycle are accepted.
REQ-018 MULT/MULTU: shift-add, one bit per cycle; {hi,lo} = full 2*WIDTH product; done in cycle N+WIDTH+1; busy=1 cycles N+1..N+WIDTH.
REQ-019 DIV/DIVU: restoring, one quotient bit per cycle; lo=quotient, hi=remainder; signed variants truncate toward zero, remainder takes dividend sign; same latency as REQ-018.
REQ-020 Divide by zero: lo = all ones, hi = a; ovf=0; latency unchanged.
REQ-021 Signed DIV of most-negative by -1: lo = most-negative, hi = 0.
REQ-022 Operands and op SHALL be captured at launch; later changes on a/b/op SHALL not affect the in-flight op.
REQ-023 start while busy=1 SHALL be ignored (no queueing).
REQ-024 NOP and unknown op codes SHALL complete in one cycle, pulse done, and leave result/hi/lo unchanged.
REQ-025 ADDU/SUBU SHALL never set ovf; ADD/SUB set ovf on signed overflow and still write result.
REQ-026 MULT/DIV ops SHALL not modify result, zero, ovf; single-cycle ops SHALL not modify hi/lo.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, result/hi/lo/iteration counter to 0, zero/ovf/busy/done to 0.
REQ-028 Reset asserted mid MUL/DIV SHALL abort the op with no done pulse; first start after release is accepted.

Structure
REQ-029 Op codes and FSM state encoding SHALL reside in shared package alu_pkg; WIDTH-dependent constants stay local.
REQ-030 Iterative multiply/divide datapath SHALL be one sub-module, alu_iter_muldiv; combinational ops stay in the top.

Verification
REQ-031 ADD a=0x7FFFFFFF b=1 -> next cycle result=0x80000000, ovf=1, done=1; ADDU same -> ovf=0.
REQ-032 SRA a=0x80000000 b=4 -> result=0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0.
REQ-033 MULT a=0xFFFFFFFE (-2) b=3 -> done at start+33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same -> hi=0x2, lo=0xFFFFFFFA.
REQ-034 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 start MULTU, pulse start with ADD at cycle +5, assert rst_n=0 at cycle +10 -> ADD ignored, no done, all outputs 0, busy=0.
REQ-036 Rerun REQ-033 with WIDTH=8: -2*3 -> hi=0xFF, lo=0xFA, done at start+9.
